// File: rtl/pipelined_add_sub_pkg.sv
// Width helpers shared by the chunked add/sub pipeline.
package pipelined_add_sub_pkg;

  // Operand bits still to be added at the input of stage k (chunk k and everything above it).
  function automatic int pending_width(int n, int chunk, int k);
    return n - k * chunk;
  endfunction

  // Result bits already known at the output of stage k (chunks 0..k).
  function automatic int done_width(int chunk, int k);
    return (k + 1) * chunk;
  endfunction

endpackage

// File: rtl/add_sub_stage.sv
// Registered CHUNK-bit ripple adder slice with carry in/out, MSB carry-in tap and a running zero flag.
module add_sub_stage #(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic             zero_in,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin,
  output logic             zero
);

  logic [CHUNK:0]   carry;
  logic [CHUNK-1:0] sum_d;

  assign carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

  // NOTE: non-blocking assignments, so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      cout    <= 1'b0;
      msb_cin <= 1'b0;
      zero    <= 1'b0;
    end else if (en) begin
      sum     <= sum_d;
      cout    <= carry[CHUNK];
      msb_cin <= carry[CHUNK-1];
      // Zero-ness accumulates chunk by chunk, like the carry.
      zero    <= zero_in & (sum_d == '0);
    end
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor: STAGES chunk-adds with registered carry ripple and a
// single global advance enable for valid/ready backpressure.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf,
  output logic         Zero
);

  localparam int CHUNK = N / STAGES;
  localparam int LAST  = STAGES - 1;

  if (N < 1 || STAGES < 1 || N % STAGES != 0) begin : g_bad_params
    $error("pipelined_add_sub: N (%0d) must be a positive multiple of STAGES (%0d)", N, STAGES);
  end

  logic         advance;
  logic         c0;
  logic [N-1:0] b_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~B : B;
  assign c0       = Cin ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SRC_W  = pending_width(N, CHUNK, k);
    localparam int DONE_W = done_width(CHUNK, k);

    logic [SRC_W-1:0]  a_src, b_src;
    logic              c_src, z_src, v_src;
    logic [CHUNK-1:0]  sum;
    logic              cout, msb_c, zero, v_q;
    logic [DONE_W-1:0] done;

    if (k == 0) begin : g_head
      assign a_src = A;
      assign b_src = b_eff;
      assign c_src = c0;
      assign z_src = 1'b1;
      assign v_src = in_valid;
      assign done  = sum;
    end else begin : g_body
      logic [DONE_W-CHUNK-1:0] lo_q;

      assign a_src = g_stage[k-1].g_skew.a_q;
      assign b_src = g_stage[k-1].g_skew.b_q;
      assign c_src = g_stage[k-1].cout;
      assign z_src = g_stage[k-1].zero;
      assign v_src = g_stage[k-1].v_q;

      // De-skew: lower result slices ride along until the last chunk is done.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lo_q <= '0;
        else if (advance) lo_q <= g_stage[k-1].done;
      end

      assign done = {sum, lo_q};
    end

    if (k < LAST) begin : g_skew
      logic [SRC_W-CHUNK-1:0] a_q, b_q;
      logic                   unused_tap;

      // Input skew: upper operand chunks wait here for their turn.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_src[SRC_W-1:CHUNK];
          b_q <= b_src[SRC_W-1:CHUNK];
        end
      end

      // Only the top chunk's MSB carry-in matters for overflow.
      assign unused_tap = msb_c;
    end

    // NOTE: no else branch for !advance -- a flop with an enable simply holds, which is the stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       v_q <= 1'b0;
      else if (advance) v_q <= v_src;
    end

    add_sub_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (advance),
      .a       (a_src[CHUNK-1:0]),
      .b       (b_src[CHUNK-1:0]),
      .cin     (c_src),
      .zero_in (z_src),
      .sum     (sum),
      .cout    (cout),
      .msb_cin (msb_c),
      .zero    (zero)
    );
  end

  assign out_valid = g_stage[LAST].v_q;
  assign Sum       = g_stage[LAST].done;
  assign Cout      = g_stage[LAST].cout;
  assign Ovf       = g_stage[LAST].msb_c ^ g_stage[LAST].cout;
  assign Zero      = g_stage[LAST].zero;

endmodule
